// File: rtl/sort_stream_checker_if.sv
// Handshake bundle between the stream checker and the sort engine under test.
// The checker drives the input side and consumes the multi-lane output side.
interface sort_stream_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_PORT   = 4
);
    logic                           sort_in_vld_o;
    logic [DATA_WIDTH-1:0]          sort_in_data_o;
    logic                           sort_in_done_vld_o;
    logic                           sort_mode_o;
    logic [OUT_PORT-1:0]            sort_out_vld_i;
    logic [OUT_PORT*DATA_WIDTH-1:0] sort_out_data_i;
    logic                           sort_out_done_vld_i;

    modport master (
        output sort_in_vld_o, sort_in_data_o, sort_in_done_vld_o, sort_mode_o,
        input  sort_out_vld_i, sort_out_data_i, sort_out_done_vld_i
    );

    modport slave (
        input  sort_in_vld_o, sort_in_data_o, sort_in_done_vld_o, sort_mode_o,
        output sort_out_vld_i, sort_out_data_i, sort_out_done_vld_i
    );
endinterface

// File: rtl/sort_stream_checker.sv
// LFSR stimulus generator and order/count/checksum self-checker for the sort engine.
// Emits len elements with a done marker, then checks the engine's lane output stream.
module sort_stream_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_PORT   = 4,
    parameter int LEN_W      = 9,
    parameter int TIMEOUT    = 4096,
    parameter int CYC_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  mode_i,
    input  logic [15:0]           seed_i,
    sort_stream_checker_if.master sif,
    output logic                  busy_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [2:0]            err_code_o,
    output logic [LEN_W-1:0]      out_count_o,
    output logic [CYC_W-1:0]      cycles_o
);

    localparam int SUM_W  = DATA_WIDTH + LEN_W;
    localparam int CNT_W  = LEN_W + $clog2(OUT_PORT + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_ORDER    = 3'd1;
    localparam logic [2:0] E_OVERFLOW = 3'd2;
    localparam logic [2:0] E_SUM      = 3'd3;
    localparam logic [2:0] E_XOR      = 3'd4;
    localparam logic [2:0] E_TIMEOUT  = 3'd5;
    localparam logic [2:0] E_SHORT    = 3'd6;
    localparam logic [2:0] E_LEN0     = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t state_q, state_nx;

    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      beat_q;
    logic                  mode_q;
    logic [15:0]           lfsr_q;
    logic [SUM_W-1:0]      sum_in_q, sum_out_q;
    logic [DATA_WIDTH-1:0] xor_in_q, xor_out_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  have_q;
    logic [WAIT_W-1:0]     wait_q;
    logic                  in_vld_q, in_done_q;
    logic [DATA_WIDTH-1:0] in_data_q;

    logic                  idle_c, launch_c, len0_c, active_c;
    logic [15:0]           seed_c;
    logic [DATA_WIDTH-1:0] elem_c, prev_c, xor_c;
    logic                  have_c, ord_err_c, overflow_c, pass_c;
    logic [SUM_W-1:0]      sum_c;
    logic [CNT_W-1:0]      cnt_c, len_ext_c;
    logic [2:0]            err_c;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign sif.sort_in_vld_o      = in_vld_q;
    assign sif.sort_in_data_o     = in_data_q;
    assign sif.sort_in_done_vld_o = in_done_q;
    assign sif.sort_mode_o        = mode_q;

    assign idle_c    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign launch_c  = idle_c && start_i && (len_i != '0);
    assign len0_c    = idle_c && start_i && (len_i == '0);
    assign active_c  = (state_q == S_SEND) || (state_q == S_WAIT);
    assign seed_c    = (seed_i == 16'h0000) ? 16'hACE1 : seed_i;
    assign len_ext_c = {{(CNT_W-LEN_W){1'b0}}, len_q};

    // Lane consumption chains the order comparison through every valid lane of the cycle.
    always_comb begin
        prev_c    = prev_q;
        have_c    = have_q;
        sum_c     = sum_out_q;
        xor_c     = xor_out_q;
        cnt_c     = {{(CNT_W-LEN_W){1'b0}}, out_count_o};
        ord_err_c = 1'b0;
        elem_c    = '0;
        for (int i = 0; i < OUT_PORT; i++) begin
            if (active_c && sif.sort_out_vld_i[i]) begin
                elem_c = sif.sort_out_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                if (have_c && (mode_q ? (elem_c > prev_c) : (elem_c < prev_c)))
                    ord_err_c = 1'b1;
                prev_c = elem_c;
                have_c = 1'b1;
                sum_c  = sum_c + SUM_W'(elem_c);
                xor_c  = xor_c ^ elem_c;
                cnt_c  = cnt_c + CNT_W'(1);
            end
        end
        overflow_c = cnt_c > len_ext_c;
    end

    always_comb begin
        err_c  = E_NONE;
        pass_c = 1'b0;
        if (active_c) begin
            if (ord_err_c)
                err_c = E_ORDER;
            else if (overflow_c)
                err_c = E_OVERFLOW;
            else if (sif.sort_out_done_vld_i) begin
                if (cnt_c != len_ext_c)
                    err_c = E_SHORT;
                else if (sum_c != sum_in_q)
                    err_c = E_SUM;
                else if (xor_c != xor_in_q)
                    err_c = E_XOR;
                else
                    pass_c = 1'b1;
            end else if ((state_q == S_WAIT) && (wait_q == WAIT_W'(TIMEOUT - 1)))
                err_c = E_TIMEOUT;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch_c)
                    state_nx = S_SEND;
                else if (len0_c)
                    state_nx = S_DONE;
            end
            S_SEND: begin
                if ((err_c != E_NONE) || pass_c)
                    state_nx = S_DONE;
                else if (beat_q == len_q)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if ((err_c != E_NONE) || pass_c)
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            beat_q      <= '0;
            mode_q      <= 1'b0;
            lfsr_q      <= 16'hACE1;
            sum_in_q    <= '0;
            sum_out_q   <= '0;
            xor_in_q    <= '0;
            xor_out_q   <= '0;
            prev_q      <= '0;
            have_q      <= 1'b0;
            wait_q      <= '0;
            in_vld_q    <= 1'b0;
            in_done_q   <= 1'b0;
            in_data_q   <= '0;
            busy_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            err_code_o  <= E_NONE;
            out_count_o <= '0;
            cycles_o    <= '0;
        end else begin
            busy_o <= (state_nx == S_SEND) || (state_nx == S_WAIT);
            if (launch_c) begin
                // The seed is the first LFSR state, so beat 1 goes out on the start edge.
                len_q       <= len_i;
                mode_q      <= mode_i;
                lfsr_q      <= lfsr_step(seed_c);
                in_vld_q    <= 1'b1;
                in_data_q   <= seed_c[DATA_WIDTH-1:0];
                in_done_q   <= (len_i == LEN_W'(1));
                beat_q      <= LEN_W'(1);
                sum_in_q    <= SUM_W'(seed_c[DATA_WIDTH-1:0]);
                xor_in_q    <= seed_c[DATA_WIDTH-1:0];
                sum_out_q   <= '0;
                xor_out_q   <= '0;
                prev_q      <= '0;
                have_q      <= 1'b0;
                wait_q      <= '0;
                pass_o      <= 1'b0;
                fail_o      <= 1'b0;
                err_code_o  <= E_NONE;
                out_count_o <= '0;
                cycles_o    <= '0;
            end else if (len0_c) begin
                in_vld_q    <= 1'b0;
                in_done_q   <= 1'b0;
                pass_o      <= 1'b0;
                fail_o      <= 1'b1;
                err_code_o  <= E_LEN0;
                out_count_o <= '0;
                cycles_o    <= '0;
            end else if (active_c) begin
                cycles_o  <= cycles_o + CYC_W'(1);
                prev_q    <= prev_c;
                have_q    <= have_c;
                sum_out_q <= sum_c;
                xor_out_q <= xor_c;
                if (!overflow_c)
                    out_count_o <= cnt_c[LEN_W-1:0];
                if (err_c != E_NONE) begin
                    fail_o     <= 1'b1;
                    err_code_o <= err_c;
                    in_vld_q   <= 1'b0;
                    in_done_q  <= 1'b0;
                end else if (pass_c) begin
                    pass_o    <= 1'b1;
                    in_vld_q  <= 1'b0;
                    in_done_q <= 1'b0;
                end else if (state_q == S_SEND) begin
                    if (beat_q != len_q) begin
                        in_vld_q  <= 1'b1;
                        in_data_q <= lfsr_q[DATA_WIDTH-1:0];
                        in_done_q <= ((beat_q + LEN_W'(1)) == len_q);
                        lfsr_q    <= lfsr_step(lfsr_q);
                        beat_q    <= beat_q + LEN_W'(1);
                        sum_in_q  <= sum_in_q + SUM_W'(lfsr_q[DATA_WIDTH-1:0]);
                        xor_in_q  <= xor_in_q ^ lfsr_q[DATA_WIDTH-1:0];
                    end else begin
                        in_vld_q  <= 1'b0;
                        in_done_q <= 1'b0;
                        wait_q    <= '0;
                    end
                end else begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
            end
        end
    end

endmodule
